// File: rtl/soc_boot_loader.sv
// ---------------------------------------------------------------------------
// soc_boot_loader
//
// Boot-time program loader. Parses framed load records from a UART byte
// stream and writes each payload byte into RAM through the bus master port.
// The CPU is held in reset until one record completes with a good checksum.
//
// Frame: SYNC, ADDR, LEN, LEN data bytes, CSUM
//        CSUM = (ADDR + LEN + sum of data) mod 256
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   rx_data   in   [7:0] received byte from UART receiver
//   rx_valid  in   rx_data valid
//   rx_ready  out  loader accepts rx_data this cycle
//   m_addr    out  [7:0] bus address
//   m_wdata   out  [7:0] bus write data
//   m_we      out  write enable (always equals m_valid)
//   m_valid   out  bus request
//   m_ready   in   bus completes request this cycle
//   cpu_hold  out  keep CPU in reset / loader owns bus
//   done      out  successful load complete (sticky)
//   err_pulse out  one-cycle pulse on checksum error or timeout
//   err_count out  [7:0] saturating error counter
// ---------------------------------------------------------------------------
module soc_boot_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter int         TIMEOUT_W      = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] m_addr,
    output logic [7:0] m_wdata,
    output logic       m_we,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       cpu_hold,
    output logic       done,
    output logic       err_pulse,
    output logic [7:0] err_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ADDR    = 3'd1;
    localparam logic [2:0] S_LEN     = 3'd2;
    localparam logic [2:0] S_DATA_RX = 3'd3;
    localparam logic [2:0] S_DATA_WR = 3'd4;
    localparam logic [2:0] S_CSUM    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]           state_q,     state_d;
    logic [7:0]           cur_addr_q,  cur_addr_d;
    logic [7:0]           remaining_q, remaining_d;
    logic [7:0]           sum_q,       sum_d;
    logic [TIMEOUT_W-1:0] tmo_q,       tmo_d;
    logic [7:0]           m_addr_q,    m_addr_d;
    logic [7:0]           m_wdata_q,   m_wdata_d;
    logic                 m_valid_q,   m_valid_d;
    logic                 cpu_hold_q,  cpu_hold_d;
    logic                 done_q,      done_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [7:0]           err_count_q, err_count_d;

    logic                 accept;
    logic                 raise_err;

    // Only the bus-write phase back-pressures the UART.
    always_comb begin
        case (state_q)
            S_IDLE, S_ADDR, S_LEN, S_DATA_RX, S_CSUM, S_DONE: rx_ready = 1'b1;
            default:                                          rx_ready = 1'b0;
        endcase
    end

    assign accept = rx_valid & rx_ready;

    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        sum_d       = sum_q;
        tmo_d       = tmo_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        m_valid_d   = m_valid_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = done_q;
        err_pulse_d = 1'b0;
        err_count_d = err_count_q;
        raise_err   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept && (rx_data == SYNC_BYTE)) begin
                    state_d = S_ADDR;
                    sum_d   = 8'h00;
                    tmo_d   = '0;
                end
            end

            S_ADDR, S_LEN, S_DATA_RX, S_CSUM: begin
                // An accept on the threshold cycle takes priority over timeout.
                if (accept) begin
                    tmo_d = '0;
                    if (state_q == S_ADDR) begin
                        cur_addr_d = rx_data;
                        sum_d      = rx_data;
                        state_d    = S_LEN;
                    end else if (state_q == S_LEN) begin
                        remaining_d = rx_data;
                        sum_d       = sum_q + rx_data;
                        state_d     = (rx_data == 8'h00) ? S_CSUM : S_DATA_RX;
                    end else if (state_q == S_DATA_RX) begin
                        m_wdata_d = rx_data;
                        m_addr_d  = cur_addr_q;
                        m_valid_d = 1'b1;
                        sum_d     = sum_q + rx_data;
                        state_d   = S_DATA_WR;
                    end else begin
                        if (rx_data == sum_q) begin
                            cpu_hold_d = 1'b0;
                            done_d     = 1'b1;
                            state_d    = S_DONE;
                        end else begin
                            raise_err = 1'b1;
                            state_d   = S_IDLE;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    raise_err = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_DATA_WR: begin
                // Request stays fixed until the bus takes it; timeout frozen.
                if (m_ready) begin
                    m_valid_d   = 1'b0;
                    cur_addr_d  = cur_addr_q + 8'd1;
                    remaining_d = remaining_q - 8'd1;
                    state_d     = (remaining_q == 8'd1) ? S_CSUM : S_DATA_RX;
                end
            end

            S_DONE: begin
                // Terminal until reset: bytes are consumed and dropped.
            end

            default: begin
                state_d   = S_IDLE;
                m_valid_d = 1'b0;
            end
        endcase

        if (raise_err) begin
            err_pulse_d = 1'b1;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others, matching real hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_addr_q  <= 8'h00;
            remaining_q <= 8'h00;
            sum_q       <= 8'h00;
            tmo_q       <= '0;
            m_addr_q    <= 8'h00;
            m_wdata_q   <= 8'h00;
            m_valid_q   <= 1'b0;
            cpu_hold_q  <= 1'b1;
            done_q      <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            sum_q       <= sum_d;
            tmo_q       <= tmo_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            m_valid_q   <= m_valid_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign m_valid   = m_valid_q;
    assign m_we      = m_valid_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_soc_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_soc_boot_loader
//
// Directed bench for soc_boot_loader, built with TIMEOUT_CYCLES=16 so the
// inter-byte timeout is reachable. A bus responder either acknowledges
// every request immediately or stalls each one for 5 cycles; a monitor logs
// completed writes and flags protocol violations for later checking.
// ---------------------------------------------------------------------------
module tb_soc_boot_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] m_addr;
    logic [7:0] m_wdata;
    logic       m_we;
    logic       m_valid;
    logic       m_ready;
    logic       cpu_hold;
    logic       done;
    logic       err_pulse;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    soc_boot_loader #(
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (16),
        .TIMEOUT_W      (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_we      (m_we),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .err_pulse (err_pulse),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Bus responder.
    logic stall_mode = 1'b0;
    int   wait_cnt   = 0;
    always @(negedge clk) begin
        if (!stall_mode) begin
            m_ready = 1'b1;
        end else if (m_valid) begin
            if (wait_cnt == 5) begin
                m_ready  = 1'b1;
                wait_cnt = 0;
            end else begin
                m_ready  = 1'b0;
                wait_cnt = wait_cnt + 1;
            end
        end else begin
            m_ready  = 1'b0;
            wait_cnt = 0;
        end
    end

    // Monitors.
    logic [15:0] wr_q[$];
    logic        pend = 1'b0;
    logic [7:0]  p_addr, p_data;
    int          stab_err = 0;
    int          rxr_err  = 0;
    int          we_err   = 0;
    int          errp_cnt = 0;

    always @(posedge clk) begin
        if (pend && (m_valid !== 1'b1 || m_addr !== p_addr || m_wdata !== p_data))
            stab_err = stab_err + 1;
        pend   = m_valid && !m_ready && !rst;
        p_addr = m_addr;
        p_data = m_wdata;
        if (m_valid && m_ready && !rst)
            wr_q.push_back({m_addr, m_wdata});
    end

    always @(negedge clk) begin
        if (m_valid && rx_ready) rxr_err = rxr_err + 1;
        if (m_we !== m_valid)    we_err  = we_err + 1;
        if (err_pulse === 1'b1)  errp_cnt = errp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n = n + 1;
        end
        check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wr_q.delete();
    endtask

    initial begin
        int n;
        int e0;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        m_ready  = 1'b1;
        @(negedge clk);
        do_reset();

        // Reset state
        check("rst_cpu_hold",  {31'd0, cpu_hold},  32'd1);
        check("rst_done",      {31'd0, done},      32'd0);
        check("rst_m_valid",   {31'd0, m_valid},   32'd0);
        check("rst_m_we",      {31'd0, m_we},      32'd0);
        check("rst_m_addr",    {24'd0, m_addr},    32'h00);
        check("rst_m_wdata",   {24'd0, m_wdata},   32'h00);
        check("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'h00);
        check("rst_rx_ready",  {31'd0, rx_ready},  32'd1);

        // 1: three-byte record, bus always ready (csum 10+03+11+22+33 = 79)
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
        send_byte(8'h11);
        check("t1_first_valid", {31'd0, m_valid}, 32'd1);
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h79);
        check("t1_done",      {31'd0, done},      32'd1);
        check("t1_cpu_hold",  {31'd0, cpu_hold},  32'd0);
        check("t1_err_count", {24'd0, err_count}, 32'd0);
        check("t1_nwrites",   wr_q.size(),        32'd3);
        if (wr_q.size() == 3) begin
            check("t1_wr0", {16'd0, wr_q[0]}, 32'h1011);
            check("t1_wr1", {16'd0, wr_q[1]}, 32'h1122);
            check("t1_wr2", {16'd0, wr_q[2]}, 32'h1233);
        end

        // 2: same record, every request stalled 5 cycles
        do_reset();
        stall_mode = 1'b1;
        e0 = errp_cnt;
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h79);
        stall_mode = 1'b0;
        check("t2_done",      {31'd0, done}, 32'd1);
        check("t2_no_err",    errp_cnt - e0, 32'd0);
        check("t2_stable",    stab_err,      32'd0);
        check("t2_rx_ready",  rxr_err,       32'd0);
        check("t2_nwrites",   wr_q.size(),   32'd3);
        if (wr_q.size() == 3)
            check("t2_wr2", {16'd0, wr_q[2]}, 32'h1233);

        // 3: bad checksum, then a good resend
        do_reset();
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h01);
        send_byte(8'h55); send_byte(8'h00);
        check("t3_err_pulse",  {31'd0, err_pulse}, 32'd1);
        check("t3_err_count",  {24'd0, err_count}, 32'd1);
        check("t3_cpu_hold",   {31'd0, cpu_hold},  32'd1);
        check("t3_done0",      {31'd0, done},      32'd0);
        check("t3_nwrites",    wr_q.size(),        32'd1);
        if (wr_q.size() == 1)
            check("t3_wr0", {16'd0, wr_q[0]}, 32'h1055);
        @(negedge clk);
        check("t3_err_pulse_1cyc", {31'd0, err_pulse}, 32'd0);
        send_byte(8'hA5); send_byte(8'h10); send_byte(8'h01);
        send_byte(8'h55); send_byte(8'h66);
        check("t3_done",        {31'd0, done},      32'd1);
        check("t3_err_count_2", {24'd0, err_count}, 32'd1);

        // 4: noise, then record crossing the top of the address space
        //    (csum FE+02+AA+BB = 65)
        do_reset();
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
        send_byte(8'hA5); send_byte(8'hFE); send_byte(8'h02);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'h65);
        check("t4_done",    {31'd0, done}, 32'd1);
        check("t4_nwrites", wr_q.size(),   32'd2);
        if (wr_q.size() == 2) begin
            check("t4_wr0", {16'd0, wr_q[0]}, 32'hFEAA);
            check("t4_wr1", {16'd0, wr_q[1]}, 32'hFFBB);
        end

        // 5: timeout after 16 idle cycles, then accept-on-threshold wins
        do_reset();
        send_byte(8'hA5); send_byte(8'h20);
        n = 0;
        while (err_pulse !== 1'b1 && n < 40) begin
            @(negedge clk);
            n = n + 1;
        end
        check("t5_tmo_cycles", n,                   32'd16);
        check("t5_err_count",  {24'd0, err_count},  32'd1);
        check("t5_done0",      {31'd0, done},       32'd0);
        send_byte(8'hA5); send_byte(8'h20);
        repeat (15) @(negedge clk);
        send_byte(8'h00);
        send_byte(8'h20);
        check("t5_done",       {31'd0, done},      32'd1);
        check("t5_err_count2", {24'd0, err_count}, 32'd1);
        check("t5_nwrites",    wr_q.size(),        32'd0);

        // 6: reset during a stalled write, then a good load, then post-done bytes
        do_reset();
        stall_mode = 1'b1;
        send_byte(8'hA5); send_byte(8'h40); send_byte(8'h01);
        send_byte(8'h77); send_byte(8'h00);
        check("t6_err_count_pre", {24'd0, err_count}, 32'd1);
        send_byte(8'hA5); send_byte(8'h40); send_byte(8'h01);
        send_byte(8'h77);
        check("t6_valid_pre", {31'd0, m_valid}, 32'd1);
        wr_q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t6_rst_m_valid",   {31'd0, m_valid},   32'd0);
        check("t6_rst_cpu_hold",  {31'd0, cpu_hold},  32'd1);
        check("t6_rst_done",      {31'd0, done},      32'd0);
        check("t6_rst_err_count", {24'd0, err_count}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        stall_mode = 1'b0;
        check("t6_abandoned", wr_q.size(), 32'd0);
        send_byte(8'hA5); send_byte(8'h40); send_byte(8'h01);
        send_byte(8'h77); send_byte(8'hB8);
        check("t6_done",    {31'd0, done}, 32'd1);
        check("t6_nwrites", wr_q.size(),   32'd1);
        if (wr_q.size() == 1)
            check("t6_wr0", {16'd0, wr_q[0]}, 32'h4077);
        send_byte(8'hA5); send_byte(8'h50); send_byte(8'h01);
        send_byte(8'h99); send_byte(8'hEA);
        repeat (3) @(negedge clk);
        check("t6_post_rx_ready", {31'd0, rx_ready},  32'd1);
        check("t6_post_nwrites",  wr_q.size(),        32'd1);
        check("t6_post_m_valid",  {31'd0, m_valid},   32'd0);
        check("t6_post_done",     {31'd0, done},      32'd1);
        check("t6_post_cpu_hold", {31'd0, cpu_hold},  32'd0);

        // 7: error counter saturation (frame A5 00 00 01, sum 00)
        do_reset();
        for (int i = 0; i < 254; i++) begin
            send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        end
        check("t7_count_fe", {24'd0, err_count}, 32'hFE);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        check("t7_count_ff", {24'd0, err_count}, 32'hFF);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        check("t7_sat_pulse", {31'd0, err_pulse}, 32'd1);
        check("t7_sat_count", {24'd0, err_count}, 32'hFF);

        check("m_we_tracks_valid", we_err, 32'd0);
        check("stability_all",     stab_err, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
